rv32i_mc_sequencer: RTL and testbench
=====================================

# rv32i_mc_sequencer

Multi-cycle control sequencer for the RV32I core. It replaces single-cycle timing with a FETCH/DECODE/EXECUTE/MEM/WB state machine that gates the existing datapath enables. Instruction and data memory are reached through req/ready handshakes, so memories may have variable latency. It also flags illegal opcodes and memory timeouts as a sticky trap, and keeps a retired-instruction counter.

## Interface
- MEM_TIMEOUT, default 16: maximum cycles a memory request may wait for ready before trapping (legal range 2..255).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- ir_opcode  in  7  opcode field of the instruction register (valid from the cycle after ir_load).
- imem_ready  in  1  instruction memory completion; Instr_rdata valid this cycle.
- dmem_ready  in  1  data memory completion; mem_rdata valid / write accepted this cycle.
- imem_req  out  1  instruction fetch request, level.
- ir_load  out  1  one-cycle pulse: capture Instr_rdata into instruction register.
- dmem_req  out  1  data memory request, level.
- dmem_we  out  1  write qualifier for dmem_req (store = 1, load = 0); 0 whenever dmem_req = 0.
- reg_write_en  out  1  one-cycle register-file write strobe.
- pc_en  out  1  one-cycle PC update strobe (datapath selects PC+4 / branch / jump target).
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout, 00 none.
- state  out  3  current state encoding, for debug.
- instret  out  32  retired-instruction count.

## Operation
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7. Values 5 and 6 are unreachable; if entered, next state is FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_load=1 for that cycle, then go to DECODE.
- DECODE: classify ir_opcode.
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR. Go to EXECUTE.
  - Any other opcode: go to TRAP with cause 01.
- EXECUTE: one cycle.
  - LOAD/STORE go to MEM.
  - BRANCH asserts pc_en, increments instret, and goes to FETCH.
  - All others go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - On dmem_ready: a LOAD goes to WB. A STORE asserts pc_en, increments instret, and goes to FETCH.
- WB: reg_write_en=1, pc_en=1, instret+1, then go to FETCH.
- TRAP:
  - All strobes and requests are 0. trap=1 and trap_cause hold.
  - Only reset leaves TRAP.
- Wait counter:
  - Cleared on entry to FETCH or MEM, and on every cycle the req is answered.
  - Increments each cycle the req is held without ready.
  - If the counter equals MEM_TIMEOUT-1 and ready is still low, go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - Ready arriving in that same cycle wins: no trap.
- instret wraps from 0xFFFFFFFF to 0. It is not incremented for a trapping instruction.
- The opcode class is latched in DECODE. ir_opcode changes after DECODE are ignored.

## Timing
- Reset values: state=FETCH, imem_req=0, ir_load=0, dmem_req=0, dmem_we=0, reg_write_en=0, pc_en=0, trap=0, trap_cause=00, instret=0.
- imem_req rises in the first cycle after reset is deasserted.
- Request outputs are Moore (state-decoded). Strobes (ir_load, pc_en, reg_write_en) are combinational on the state plus the ready input of the current cycle.
- Zero-wait latency, measured from FETCH entry to the next FETCH entry:
  - BRANCH: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle adds 1 to these latencies.
- Handshake rules:
  - A req stays high until ready is seen.
  - Ready while the matching req is low is ignored.
  - A new req is issued no earlier than the cycle after the previous completion.
- Reset mid-operation (any state, including waiting or TRAP) returns to reset values on the next edge. No strobe fires in the reset cycle.
- pc_en and reg_write_en are each asserted exactly once per retired instruction. reg_write_en is never asserted for BRANCH or STORE.

## Test plan
- R-type 0110011, imem_ready tied high → state sequence 0,1,2,4,0. ir_load in cycle 0, reg_write_en+pc_en in cycle 3. instret 0→1.
- LOAD with dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0. WB follows, total 8 cycles. reg_write_en asserted once.
- STORE then BRANCH, zero-wait → STORE: dmem_we=1 in MEM, pc_en on MEM completion, no reg_write_en. BRANCH: pc_en in EXECUTE. instret=2 after 7 cycles.
- Opcode 0000000 → TRAP after DECODE, trap_cause=01. Outputs frozen for 20 cycles. reset returns state=0, trap=0.
- imem_ready held low, MEM_TIMEOUT=16 → trap with cause 10 after exactly 16 FETCH cycles. A second run with ready in the 16th cycle → no trap, proceeds to DECODE.
- Preload instret near 0xFFFFFFFF (force), retire 2 instructions → wraps to 0x00000001. Assert reset mid-MEM → dmem_req=0 on the next cycle.

Source files
------------

// File: rtl/rv32i_mc_sequencer_if.sv
// Handshake and control bundle between the multi-cycle sequencer,
// the instruction register and the instruction/data memories.
interface rv32i_mc_sequencer_if;
    logic [6:0]  ir_opcode;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_write_en;
    logic        pc_en;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;

    modport master (
        input  ir_opcode, imem_ready, dmem_ready,
        output imem_req, ir_load, dmem_req, dmem_we,
        output reg_write_en, pc_en, trap, trap_cause,
        output state, instret
    );

    modport slave (
        output ir_opcode, imem_ready, dmem_ready,
        input  imem_req, ir_load, dmem_req, dmem_we,
        input  reg_write_en, pc_en, trap, trap_cause,
        input  state, instret
    );
endinterface

// File: rtl/rv32i_mc_sequencer.sv
// RV32I multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB
// with req/ready memory handshakes, sticky trap and retired counter.
module rv32i_mc_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    rv32i_mc_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH
    } cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    cls_t        cls_q, op_cls;
    logic        op_legal;
    logic [1:0]  cause_q, cause_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] instret_q;
    logic        imem_req, dmem_req, dmem_we;
    logic        ir_load, pc_en, reg_write_en;

    always_comb begin
        op_legal = 1'b1;
        op_cls   = CL_ALU;
        case (bus.ir_opcode)
            7'b0110011: op_cls = CL_ALU;
            7'b0010011: op_cls = CL_ALU;
            7'b0000011: op_cls = CL_LOAD;
            7'b0100011: op_cls = CL_STORE;
            7'b1100011: op_cls = CL_BRANCH;
            7'b0110111: op_cls = CL_ALU;
            7'b0010111: op_cls = CL_ALU;
            7'b1101111: op_cls = CL_ALU;
            7'b1100111: op_cls = CL_ALU;
            default:    op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        reg_write_en = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end
            end
            DECODE: begin
                if (op_legal) begin
                    state_d = EXECUTE;
                end else begin
                    state_d = TRAP;
                    cause_d = 2'b01;
                end
            end
            EXECUTE: begin
                case (cls_q)
                    CL_LOAD, CL_STORE: state_d = MEM;
                    CL_BRANCH: begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CL_STORE);
                if (bus.dmem_ready) begin
                    if (cls_q == CL_STORE) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = TRAP;
                    cause_d = 2'b11;
                end
            end
            WB: begin
                reg_write_en = 1'b1;
                pc_en        = 1'b1;
                state_d      = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Counter restarts on every state change, so FETCH/MEM entry clears it.
    always_comb begin
        wait_d = 8'd0;
        if (state_d == state_q &&
            ((imem_req && !bus.imem_ready) ||
             (dmem_req && !bus.dmem_ready)))
            wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            cls_q     <= CL_ALU;
            cause_q   <= 2'b00;
            wait_q    <= 8'd0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
            if (state_q == DECODE)
                cls_q <= op_cls;
            if (pc_en)
                instret_q <= instret_q + 32'd1;
        end
    end

    // Outputs are held quiet while reset is asserted.
    assign bus.imem_req     = imem_req & ~reset;
    assign bus.dmem_req     = dmem_req & ~reset;
    assign bus.dmem_we      = dmem_we & ~reset;
    assign bus.ir_load      = ir_load & ~reset;
    assign bus.pc_en        = pc_en & ~reset;
    assign bus.reg_write_en = reg_write_en & ~reset;
    assign bus.trap         = (state_q == TRAP);
    assign bus.trap_cause   = cause_q;
    assign bus.state        = state_q;
    assign bus.instret      = instret_q;
endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// Scoreboard bench for rv32i_mc_sequencer: directed instruction runs
// push expected output events; a negedge monitor pops and compares.
module tb_rv32i_mc_sequencer;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic [2:0]  st;
        logic        il;
        logic        dr;
        logic        dw;
        logic        rw;
        logic        pe;
        logic [31:0] ir;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_ir;
    ev_t q[$];
    ev_t mon_a, mon_e;

    rv32i_mc_sequencer_if bus();

    rv32i_mc_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ir_load || bus.pc_en || bus.reg_write_en || bus.dmem_req) begin
            mon_a = {bus.state, bus.ir_load, bus.dmem_req, bus.dmem_we,
                     bus.reg_write_en, bus.pc_en, bus.instret};
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got %h want none", mon_a);
            end else begin
                mon_e = q.pop_front();
                if (mon_a !== mon_e) begin
                    n_bad++;
                    $display("FAIL event: got st=%0d il=%b dr=%b dw=%b rw=%b pe=%b ir=%h want st=%0d il=%b dr=%b dw=%b rw=%b pe=%b ir=%h",
                             mon_a.st, mon_a.il, mon_a.dr, mon_a.dw, mon_a.rw, mon_a.pe, mon_a.ir,
                             mon_e.st, mon_e.il, mon_e.dr, mon_e.dw, mon_e.rw, mon_e.pe, mon_e.ir);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic il,
                        input logic dr, input logic dw,
                        input logic rw, input logic pe);
        q.push_back({st, il, dr, dw, rw, pe, exp_ir});
    endtask

    task automatic run_instr(input logic [6:0] op, input int iw, input int dw);
        logic ls, st;
        ls = (op == OP_LD) || (op == OP_ST);
        st = (op == OP_ST);
        chk("fetch_entry", 32'(bus.state), 32'd0);
        for (int i = 0; i < iw; i++) begin
            bus.imem_ready = 1'b0;
            chk("imem_req_wait", 32'(bus.imem_req), 32'd1);
            tick();
        end
        bus.imem_ready = 1'b1;
        bus.ir_opcode  = op;
        push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.imem_ready = 1'b0;
        chk("decode", 32'(bus.state), 32'd1);
        tick();
        chk("execute", 32'(bus.state), 32'd2);
        if (op == OP_BR) begin
            push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            exp_ir++;
        end else begin
            tick();
            if (ls) begin
                chk("mem", 32'(bus.state), 32'd3);
                for (int i = 0; i < dw; i++) begin
                    bus.dmem_ready = 1'b0;
                    push(3'd3, 1'b0, 1'b1, st, 1'b0, 1'b0);
                    tick();
                end
                bus.dmem_ready = 1'b1;
                push(3'd3, 1'b0, 1'b1, st, 1'b0, st);
                tick();
                bus.dmem_ready = 1'b0;
                if (st) exp_ir++;
            end
            if (!st) begin
                chk("wb", 32'(bus.state), 32'd4);
                push(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                tick();
                exp_ir++;
            end
        end
        chk("retire_state", 32'(bus.state), 32'd0);
        chk("instret", bus.instret, exp_ir);
    endtask

    task automatic do_reset();
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ir = 32'd0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_ir         = 32'd0;
        reset          = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.ir_opcode  = 7'd0;
        tick();
        tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_ir_load", 32'(bus.ir_load), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_rwe", 32'(bus.reg_write_en), 32'd0);
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rst_trap", 32'(bus.trap), 32'd0);
        chk("rst_cause", 32'(bus.trap_cause), 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        reset = 1'b0;
        #1;
        chk("imem_req_rise", 32'(bus.imem_req), 32'd1);

        run_instr(OP_R, 0, 0);
        run_instr(OP_LD, 0, 3);
        run_instr(OP_ST, 0, 0);
        run_instr(OP_BR, 0, 0);
        run_instr(OP_JAL, 2, 0);
        run_instr(OP_ST, 1, 2);
        run_instr(OP_I, 0, 0);
        chk("instret_7", bus.instret, 32'd7);

        // imem never answers: trap after exactly 16 FETCH cycles
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("fetch_16th", 32'(bus.state), 32'd0);
        tick();
        chk("itmo_state", 32'(bus.state), 32'd7);
        chk("itmo_cause", 32'(bus.trap_cause), 32'd2);
        chk("itmo_trap", 32'(bus.trap), 32'd1);
        chk("itmo_instret", bus.instret, 32'd7);
        do_reset();
        chk("post_rst_instret", bus.instret, 32'd0);
        run_instr(OP_R, 15, 0);

        // illegal opcode, then 20 frozen cycles despite ready inputs
        bus.imem_ready = 1'b1;
        bus.ir_opcode  = 7'b0000000;
        push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.imem_ready = 1'b0;
        chk("ill_decode", 32'(bus.state), 32'd1);
        tick();
        chk("ill_state", 32'(bus.state), 32'd7);
        chk("ill_cause", 32'(bus.trap_cause), 32'd1);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ready = 1'b1;
            bus.dmem_ready = 1'b1;
            bus.ir_opcode  = OP_R;
            tick();
            chk("frz_state", 32'(bus.state), 32'd7);
            chk("frz_reqs", {30'd0, bus.imem_req, bus.dmem_req}, 32'd0);
            chk("frz_trap", {29'd0, bus.trap, bus.trap_cause}, 32'h5);
        end
        chk("ill_instret", bus.instret, 32'd1);
        do_reset();
        chk("ill_rst_state", 32'(bus.state), 32'd0);
        chk("ill_rst_trap", 32'(bus.trap), 32'd0);
        chk("ill_rst_cause", 32'(bus.trap_cause), 32'd0);

        // dmem never answers a store
        bus.imem_ready = 1'b1;
        bus.ir_opcode  = OP_ST;
        push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.imem_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            push(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("dtmo_state", 32'(bus.state), 32'd7);
        chk("dtmo_cause", 32'(bus.trap_cause), 32'd3);
        chk("dtmo_instret", bus.instret, 32'd0);
        do_reset();

        // reset in the middle of a load's MEM wait
        bus.imem_ready = 1'b1;
        bus.ir_opcode  = OP_LD;
        push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.imem_ready = 1'b0;
        tick();
        tick();
        push(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mid_mem_state", 32'(bus.state), 32'd3);
        reset = 1'b1;
        tick();
        chk("mid_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        reset = 1'b0;
        exp_ir = 32'd0;
        #1;
        chk("mid_rel_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("mid_rel_imem_req", 32'(bus.imem_req), 32'd1);

        // instret wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_ir = 32'hFFFF_FFFF;
        chk("preload", bus.instret, 32'hFFFF_FFFF);
        run_instr(OP_BR, 0, 0);
        run_instr(OP_BR, 0, 0);
        chk("wrap", bus.instret, 32'h0000_0001);

        bus.imem_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("sb_drain", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
